// File: rtl/alu_seq.sv
`timescale 1ns/1ps
// alu_seq: sequential ALU with a valid/ready request side and a valid/ready
// result side. Single-cycle functions complete on the accepting edge; MUL
// runs a shift-add loop, one multiplier bit per cycle.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// MUL   | shift-add multiply in progress, WIDTH iterations
// DONE  | result and flags valid, held until out_ready
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   request handshake
//   op1, op2, func        operands (two's complement) and function code
//   out_valid / out_ready result handshake
//   result, zero, sign, ovf, carry  registered result and flags
//   busy                  high whenever the FSM is not in IDLE
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [2:0]       func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             sign,
  output logic             ovf,
  output logic             carry,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] F_NOP = 3'd0;
  localparam logic [2:0] F_ADD = 3'd1;
  localparam logic [2:0] F_SUB = 3'd2;
  localparam logic [2:0] F_AND = 3'd3;
  localparam logic [2:0] F_OR  = 3'd4;
  localparam logic [2:0] F_XOR = 3'd5;
  localparam logic [2:0] F_MUL = 3'd6;
  localparam logic [2:0] F_SLT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] op_a_q;   // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]   op_b_q;   // multiplier, shifted right each iteration
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;

  logic               accept;
  logic               mul_last;
  logic [2*WIDTH-1:0] acc_step;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_carry;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid && in_ready;
  assign mul_last  = (state_q == MUL) && (cnt_q == CNT_LAST);
  assign acc_step  = acc_q + (op_b_q[0] ? op_a_q : '0);

  // Single-cycle functions evaluate straight from the request inputs so the
  // result can be registered on the accepting edge.
  always_comb begin
    sum_ext   = {1'b0, op1} + {1'b0, op2};
    diff      = op1 - op2;
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    case (func)
      F_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != op1[WIDTH-1]);
      end
      F_SUB: begin
        alu_res   = diff;
        alu_carry = (op1 < op2);
        alu_ovf   = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                    (diff[WIDTH-1] != op1[WIDTH-1]);
      end
      F_AND:   alu_res = op1 & op2;
      F_OR:    alu_res = op1 | op2;
      F_XOR:   alu_res = op1 ^ op2;
      F_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (func == F_MUL) ? MUL : DONE;
        end
      end
      MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q <= '0;
      op_b_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
      zero   <= 1'b0;
      sign   <= 1'b0;
      ovf    <= 1'b0;
      carry  <= 1'b0;
    end else if (accept) begin
      op_a_q <= {{WIDTH{1'b0}}, op1};
      op_b_q <= op2;
      acc_q  <= '0;
      cnt_q  <= '0;
      if (func != F_MUL) begin
        result <= alu_res;
        zero   <= (alu_res == '0);
        sign   <= alu_res[WIDTH-1];
        ovf    <= alu_ovf;
        carry  <= alu_carry;
      end
    end else if (state_q == MUL) begin
      acc_q  <= acc_step;
      op_a_q <= op_a_q << 1;
      op_b_q <= op_b_q >> 1;
      cnt_q  <= cnt_q + CW'(1);
      // The last iteration's sum is the full product; register it directly.
      if (mul_last) begin
        result <= acc_step[WIDTH-1:0];
        zero   <= (acc_step[WIDTH-1:0] == '0);
        sign   <= acc_step[WIDTH-1];
        ovf    <= |acc_step[2*WIDTH-1:WIDTH];
        carry  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
`timescale 1ns/1ps
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] op1 = '0;
  logic [W-1:0] op2 = '0;
  logic [2:0]   func = 3'd0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero, sign, ovf, carry, busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .func(func), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .sign(sign),
    .ovf(ovf), .carry(carry), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for exactly one accepting edge, then scramble inputs.
  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] f);
    check({tag, "_ready_before"}, in_ready, 1);
    in_valid = 1'b1;
    op1 = a;
    op2 = b;
    func = f;
    step();
    in_valid = 1'b0;
    op1 = ~a;
    op2 = ~b;
    func = f ^ 3'd5;
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] r, input logic z,
                           input logic s, input logic o, input logic c);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_result"}, result, r);
    check({tag, "_zero"}, zero, z);
    check({tag, "_sign"}, sign, s);
    check({tag, "_ovf"}, ovf, o);
    check({tag, "_carry"}, carry, c);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_back"}, in_ready, 1);
  endtask

  // Single-cycle op: out_valid must be up on the cycle right after acceptance.
  task automatic alu_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] f, input logic [W-1:0] r, input logic z,
                        input logic s, input logic o, input logic c);
    issue(tag, a, b, f);
    check_out(tag, r, z, s, o, c);
    release_out(tag);
  endtask

  // Multiply: count cycles from acceptance until out_valid, busy must stay high.
  task automatic mul_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic z, input logic s, input logic o);
    int cyc;
    bit busy_ok;
    issue(tag, a, b, 3'd6);
    cyc = 1;
    busy_ok = 1'b1;
    while (!out_valid && cyc < 30) begin
      if (!busy) busy_ok = 1'b0;
      step();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_busy_held"}, {31'd0, busy_ok}, 1);
    check({tag, "_busy_done"}, busy, 1);
    check_out(tag, r, z, s, o, 1'b0);
    release_out(tag);
  endtask

  initial begin
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_flags", {zero, sign, ovf, carry}, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    alu_op("add_7f_01", 8'h7F, 8'h01, 3'd1, 8'h80, 0, 1, 1, 0);
    alu_op("add_ff_01", 8'hFF, 8'h01, 3'd1, 8'h00, 1, 0, 0, 1);
    alu_op("sub_00_01", 8'h00, 8'h01, 3'd2, 8'hFF, 0, 1, 0, 1);
    alu_op("sub_80_01", 8'h80, 8'h01, 3'd2, 8'h7F, 0, 0, 1, 0);
    alu_op("and", 8'hF0, 8'h3C, 3'd3, 8'h30, 0, 0, 0, 0);
    alu_op("or", 8'hF0, 8'h0F, 3'd4, 8'hFF, 0, 1, 0, 0);
    alu_op("xor", 8'hFF, 8'h0F, 3'd5, 8'hF0, 0, 1, 0, 0);
    alu_op("slt_ff_01", 8'hFF, 8'h01, 3'd7, 8'h01, 0, 0, 0, 0);
    alu_op("slt_01_ff", 8'h01, 8'hFF, 3'd7, 8'h00, 1, 0, 0, 0);
    alu_op("nop", 8'h12, 8'h34, 3'd0, 8'h00, 1, 0, 0, 0);

    mul_op("mul_10_10", 8'h10, 8'h10, 8'h00, 1, 0, 1);
    mul_op("mul_0f_0f", 8'h0F, 8'h0F, 8'hE1, 0, 1, 0);

    // Back-pressure in DONE with stray request pulses.
    issue("stall", 8'h05, 8'h03, 3'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      op1 = 8'hAA;
      op2 = 8'h55;
      func = 3'd2;
      step();
      check("stall_result", result, 8'h08);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    release_out("stall");
    step();
    check("stall_no_extra", out_valid, 0);
    check("stall_still_idle", busy, 0);

    // Reset in the middle of a multiply.
    issue("mulrst", 8'h0F, 8'h0F, 3'd6);
    step();
    step();
    step();
    check("mulrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mulrst_out_valid", out_valid, 0);
    check("mulrst_busy", busy, 0);
    check("mulrst_result", result, 0);
    check("mulrst_flags", {zero, sign, ovf, carry}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mulrst_in_ready", in_ready, 1);
    for (int i = 0; i < 10; i++) step();
    check("mulrst_no_output", out_valid, 0);
    alu_op("add_01_02", 8'h01, 8'h02, 3'd1, 8'h03, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
